epmp_pc_seq: RTL and testbench
==============================

# epmp_pc_seq

Fetch/execute sequencer for the EPMP processor. It drives the program counter's control strobes (`PC_Load_En`, `PC_Inc_nLoad`, `PC_Out_En`) and the memory read handshake. It fetches 1–3 byte instructions into the instruction and operand registers, hands each instruction to the execute unit, and loads branch targets into the PC from the internal IBH/IBL bus. It sits between the PC, program memory, instruction decoder and execute unit.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of consecutive FETCH cycles without `Mem_Ack` before abort. Used only with the timeout macro; legal range 2–255.

- `clk`  in  1  system clock; everything is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  level; enables instruction fetching.
- `Mem_Ack`  in  1  memory read data valid on the data bus this cycle.
- `Instr_Len`  in  2  byte count from the decoder (0 or 1 means 1 byte; 2 or 3 bytes). Valid from the cycle after `IR_Load`.
- `Exec_Done`  in  1  execute unit has finished the current instruction.
- `Branch_Req`  in  1  qualifies `Exec_Done`; the target is driven on IBH/IBL by the execute unit.
- `PC_Load_En`  out  1  PC update strobe.
- `PC_Inc_nLoad`  out  1  1 = increment PC, 0 = load PC from IBH/IBL.
- `PC_Out_En`  out  1  PC drives IBH/IBL (used as the memory address).
- `Mem_Rd`  out  1  memory read request.
- `IR_Load`  out  1  latch byte 0 into the instruction register.
- `Opnd_Load`  out  2  bit0 latches byte 1, bit1 latches byte 2.
- `Exec_Start`  out  1  one-cycle pulse to the execute unit.
- `Busy`  out  1  state is not IDLE.
- `Instr_Count`  out  16  number of completed instructions; wraps 0xFFFF→0x0000.
- `Bus_Err`  out  1  sticky flag for a fetch timeout. Tied to 0 when the timeout macro is not defined.

## Operation
- States: IDLE, FETCH, INC, DISPATCH, EXEC, BRANCH. Internal byte index `bidx` (0–2).
- IDLE
  - All strobes are 0.
  - If `Run`=1: set `bidx`=0 and go to FETCH.
- FETCH
  - `PC_Out_En`=1 and `Mem_Rd`=1, held until `Mem_Ack`.
  - In the `Mem_Ack` cycle, the load strobes are combinational: `IR_Load` if `bidx`=0, `Opnd_Load[bidx-1]` otherwise.
  - On `Mem_Ack`: go to INC.
- INC
  - `PC_Load_En`=1 and `PC_Inc_nLoad`=1; `PC_Out_En`=0.
  - If `bidx`+1 < effective length: increment `bidx` and go to FETCH.
  - Otherwise go to DISPATCH.
  - The length is sampled from `Instr_Len` whenever `bidx`≥0 in INC. The decoder holds it stable from the cycle after `IR_Load`.
- DISPATCH
  - `Exec_Start`=1 for exactly one cycle; `Exec_Done` is ignored here.
  - Go to EXEC.
- EXEC
  - Wait for `Exec_Done`.
  - On `Exec_Done`=1 with `Branch_Req`=1: go to BRANCH.
  - On `Exec_Done`=1 with `Branch_Req`=0: increment `Instr_Count`, then go to FETCH if `Run`=1 (with `bidx`=0), else IDLE.
- BRANCH
  - `PC_Load_En`=1, `PC_Inc_nLoad`=0, `PC_Out_En`=0, so the PC loads IBH/IBL.
  - Increment `Instr_Count`, then go to FETCH if `Run`=1, else IDLE.
- `Run` deasserted mid-instruction takes effect only at instruction completion; the current instruction always finishes.
- Bus safety invariant: `PC_Out_En`=1 never coincides with `PC_Load_En`=1.

## Timing
- Reset values: state IDLE, `bidx`=0, `Instr_Count`=0, `Bus_Err`=0, all strobes 0, `Busy`=0.
- `Reset` asserted in any state returns to IDLE on the next edge, with no PC strobe issued in that cycle.
- All outputs are Moore-decoded from the registered state, except `IR_Load`/`Opnd_Load`, which are FETCH & `Mem_Ack`.
- Zero-wait memory costs 2 cycles per byte.
- 1-byte instruction with `Exec_Done` in the first EXEC cycle: FETCH, INC, DISPATCH, EXEC = 4 cycles before the next FETCH; a branch adds 1 cycle.
- Each memory wait cycle adds 1 cycle in FETCH.
- `Mem_Ack` outside FETCH is ignored.

## Configuration
- Macro: `EPMP_SEQ_FETCH_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entry to FETCH and counts each FETCH cycle without `Mem_Ack`.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, set `Bus_Err`=1, and do not increment the PC.
  - `Bus_Err` clears only on `Reset`.
  - While `Bus_Err`=1, IDLE does not restart even if `Run`=1.
- Not defined: FETCH waits indefinitely, `Bus_Err` is constant 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- **Zero-wait 1-byte instruction:** Reset, then `Run`=1, `Mem_Ack` tied 1, `Instr_Len`=1, `Exec_Done` on the first EXEC cycle. Required: `Exec_Start` pulses every 4 cycles, PC advances by 1 per instruction, `Instr_Count`=3 after 12 cycles.
- **3-byte instruction with one wait state per byte:** `Instr_Len`=3. Required:
  - `IR_Load`, `Opnd_Load`=01, then `Opnd_Load`=10, each in a `Mem_Ack` cycle.
  - PC advances by 3.
  - `Exec_Start` arrives 9 cycles after the first FETCH.
- **Branch:** `Exec_Done`=1 and `Branch_Req`=1 with 0x1234 driven on IBH/IBL. Required: one cycle with `PC_Load_En`=1, `PC_Inc_nLoad`=0, `PC_Out_En`=0; the next FETCH address is 0x1234.
- **Run drop:** `Run` falls during FETCH of byte 1 of a 2-byte instruction. Required: the instruction completes, `Instr_Count` increments, then IDLE with `Busy`=0.
- **Reset mid-operation:** `Reset` pulsed in INC, then in EXEC. Required: IDLE next cycle, all strobes 0, `Instr_Count`=0.
- **Timeout (macro defined):** `TIMEOUT_CYCLES`=4 and `Mem_Ack` held 0. Required: IDLE after 4 FETCH cycles, `Bus_Err`=1, PC unchanged, no restart with `Run`=1 until `Reset`.

Source files
------------

// File: rtl/epmp_pc_seq.sv
// Fetch/execute sequencer for the EPMP processor: PC strobes, memory read handshake, IR/operand loads.
// Optional fetch timeout with sticky Bus_Err is enabled by defining EPMP_SEQ_FETCH_TIMEOUT_EN.
module epmp_pc_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Mem_Ack,
  input  logic [1:0]  Instr_Len,
  input  logic        Exec_Done,
  input  logic        Branch_Req,
  output logic        PC_Load_En,
  output logic        PC_Inc_nLoad,
  output logic        PC_Out_En,
  output logic        Mem_Rd,
  output logic        IR_Load,
  output logic [1:0]  Opnd_Load,
  output logic        Exec_Start,
  output logic        Busy,
  output logic [15:0] Instr_Count,
  output logic        Bus_Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INC,
    S_DISPATCH,
    S_EXEC,
    S_BRANCH
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  len_eff;
  logic        fetch_timeout;
  logic        bus_err_q;
  logic        strobe_en;
  logic        fetch_ack;

`ifdef EPMP_SEQ_FETCH_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_q, wait_d;

  // Counter is zero outside FETCH, so it is already clear on every entry to FETCH.
  always_comb begin
    wait_d = 8'd0;
    if (state_q == S_FETCH && !Mem_Ack) wait_d = wait_q + 8'd1;
  end

  assign fetch_timeout = (state_q == S_FETCH) && !Mem_Ack && (wait_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (Reset) begin
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (fetch_timeout) bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign fetch_timeout      = 1'b0;
  assign bus_err_q          = 1'b0;
`endif

  // Lengths 0 and 1 both mean a single byte.
  assign len_eff = (Instr_Len < 2'd2) ? 2'd1 : Instr_Len;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Run && !bus_err_q) begin
          bidx_d  = 2'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (Mem_Ack)            state_d = S_INC;
        else if (fetch_timeout) state_d = S_IDLE;
      end
      S_INC: begin
        if (({1'b0, bidx_q} + 3'd1) < {1'b0, len_eff}) begin
          bidx_d  = bidx_q + 2'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: state_d = S_EXEC;
      S_EXEC: begin
        if (Exec_Done) begin
          if (Branch_Req) begin
            state_d = S_BRANCH;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            bidx_d  = 2'd0;
            state_d = Run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_BRANCH: begin
        cnt_d   = cnt_q + 16'd1;
        bidx_d  = 2'd0;
        state_d = Run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      bidx_q  <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are suppressed while Reset is high so an aborted state never moves the PC.
  assign strobe_en    = !Reset;
  assign fetch_ack    = strobe_en && (state_q == S_FETCH) && Mem_Ack;

  assign PC_Out_En    = strobe_en && (state_q == S_FETCH);
  assign Mem_Rd       = strobe_en && (state_q == S_FETCH);
  assign PC_Load_En   = strobe_en && ((state_q == S_INC) || (state_q == S_BRANCH));
  assign PC_Inc_nLoad = strobe_en && (state_q == S_INC);
  assign Exec_Start   = strobe_en && (state_q == S_DISPATCH);
  assign IR_Load      = fetch_ack && (bidx_q == 2'd0);
  assign Opnd_Load    = {fetch_ack && (bidx_q == 2'd2), fetch_ack && (bidx_q == 2'd1)};
  assign Busy         = (state_q != S_IDLE);
  assign Instr_Count  = cnt_q;
  assign Bus_Err      = bus_err_q;

endmodule

// File: tb/tb_epmp_pc_seq.sv
// Self-checking bench for epmp_pc_seq: directed scenarios plus randomized instruction streams
// checked against a transaction-level model of PC, fetch timing and instruction count.
module tb_epmp_pc_seq;

  logic        clk;
  logic        Reset;
  logic        Run;
  logic        Mem_Ack;
  logic [1:0]  Instr_Len;
  logic        Exec_Done;
  logic        Branch_Req;
  logic        PC_Load_En;
  logic        PC_Inc_nLoad;
  logic        PC_Out_En;
  logic        Mem_Rd;
  logic        IR_Load;
  logic [1:0]  Opnd_Load;
  logic        Exec_Start;
  logic        Busy;
  logic [15:0] Instr_Count;
  logic        Bus_Err;

  // Environment: a PC register driven by the DUT strobes and the shared IBH/IBL bus.
  logic [15:0] pc = 16'h0100;
  logic [15:0] ext_bus = 16'h0000;
  logic [15:0] ibus;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_pc;
  int          model_cnt;
  bit          in_fetch;

  epmp_pc_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Run          (Run),
    .Mem_Ack      (Mem_Ack),
    .Instr_Len    (Instr_Len),
    .Exec_Done    (Exec_Done),
    .Branch_Req   (Branch_Req),
    .PC_Load_En   (PC_Load_En),
    .PC_Inc_nLoad (PC_Inc_nLoad),
    .PC_Out_En    (PC_Out_En),
    .Mem_Rd       (Mem_Rd),
    .IR_Load      (IR_Load),
    .Opnd_Load    (Opnd_Load),
    .Exec_Start   (Exec_Start),
    .Busy         (Busy),
    .Instr_Count  (Instr_Count),
    .Bus_Err      (Bus_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ibus = PC_Out_En ? pc : ext_bus;

  always @(posedge clk) begin
    if (PC_Load_En) pc <= PC_Inc_nLoad ? pc + 16'd1 : ibus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus safety: the PC never drives the bus while it is being loaded.
  always @(negedge clk) begin
    check("bus_safety", {31'd0, PC_Out_En & PC_Load_En}, 32'd0);
  end

  // One whole instruction: per byte (waits+1) FETCH cycles then one INC, then DISPATCH,
  // (xwait+1) EXEC cycles and an optional BRANCH cycle.
  task automatic run_instr(input logic [1:0] len, input int w0, input int w1, input int w2,
                           input int xwait, input bit br, input logic [15:0] tgt,
                           input bit run_end);
    int          w[3];
    int          nb;
    bit          ack;
    logic [1:0]  exp_op;
    logic [15:0] start;
    w     = '{w0, w1, w2};
    nb    = (len < 2) ? 1 : int'(len);
    start = model_pc;
    if (!in_fetch) begin
      Run = 1'b1;
      Mem_Ack = 1'($urandom);
      #1;
      check("idle_busy", {31'd0, Busy}, 32'd0);
      check("idle_strobes", {28'd0, PC_Load_En, PC_Out_En, Mem_Rd, Exec_Start}, 32'd0);
      step();
    end
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= w[b]; k++) begin
        ack        = (k == w[b]);
        Mem_Ack    = ack;
        Instr_Len  = len;
        Run        = 1'($urandom);
        Exec_Done  = 1'($urandom);
        Branch_Req = 1'($urandom);
        #1;
        exp_op = !ack ? 2'b00 : (b == 1) ? 2'b01 : (b == 2) ? 2'b10 : 2'b00;
        check("fetch_strobes", {28'd0, Mem_Rd, PC_Out_En, PC_Load_En, Exec_Start}, 32'hC);
        check("fetch_addr", {16'd0, ibus}, {16'd0, start + 16'(b)});
        check("ir_load", {31'd0, IR_Load}, {31'd0, ack && (b == 0)});
        check("opnd_load", {30'd0, Opnd_Load}, {30'd0, exp_op});
        step();
      end
      Mem_Ack = 1'($urandom);
      #1;
      check("inc_strobes", {25'd0, PC_Load_En, PC_Inc_nLoad, PC_Out_En, Mem_Rd, IR_Load, Opnd_Load},
            32'h60);
      step();
    end
    Exec_Done = 1'($urandom);
    Mem_Ack   = 1'($urandom);
    #1;
    check("dispatch", {29'd0, Exec_Start, PC_Load_En, Busy}, 32'h5);
    step();
    for (int k = 0; k <= xwait; k++) begin
      Exec_Done  = (k == xwait);
      Branch_Req = (k == xwait) ? br : 1'($urandom);
      Run        = (k == xwait) ? run_end : 1'($urandom);
      #1;
      check("exec_strobes", {28'd0, Exec_Start, PC_Load_En, PC_Out_En, Busy}, 32'h1);
      step();
    end
    Exec_Done  = 1'b0;
    Branch_Req = 1'b0;
    if (br) begin
      ext_bus = tgt;
      Run     = run_end;
      #1;
      check("branch_strobes", {29'd0, PC_Load_En, PC_Inc_nLoad, PC_Out_En}, 32'h4);
      check("branch_count", {16'd0, Instr_Count}, 32'(model_cnt));
      step();
      model_pc = tgt;
    end else begin
      model_pc = start + 16'(nb);
    end
    model_cnt = (model_cnt + 1) % 65536;
    #1;
    check("instr_count", {16'd0, Instr_Count}, 32'(model_cnt));
    check("busy_after", {31'd0, Busy}, {31'd0, run_end});
    check("pc_after", {16'd0, pc}, {16'd0, model_pc});
    check("bus_err_clear", {31'd0, Bus_Err}, 32'd0);
    in_fetch = run_end;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Mem_Ack = 1'b0; Instr_Len = 2'd1;
    Exec_Done = 1'b0; Branch_Req = 1'b0;
    model_pc = 16'h0100; model_cnt = 0; in_fetch = 1'b0;
    step(); step();
    Reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_count", {16'd0, Instr_Count}, 32'd0);
    check("rst_bus_err", {31'd0, Bus_Err}, 32'd0);
    check("rst_strobes", {25'd0, PC_Load_En, PC_Inc_nLoad, PC_Out_En, Mem_Rd, IR_Load, Exec_Start,
          Busy}, 32'd0);

    // Zero-wait 1-byte instructions back to back.
    run_instr(2'd1, 0, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    run_instr(2'd1, 0, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    run_instr(2'd0, 0, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    check("zero_wait_count3", {16'd0, Instr_Count}, 32'd3);

    // 3-byte instruction, one wait state per byte.
    run_instr(2'd3, 1, 1, 1, 0, 1'b0, 16'h0, 1'b1);

    // Branch to 0x1234, then a 2-byte instruction fetched from there; Run toggles mid-way.
    run_instr(2'd1, 0, 0, 0, 1, 1'b1, 16'h1234, 1'b1);
    run_instr(2'd2, 0, 2, 0, 0, 1'b0, 16'h0, 1'b0);

    // Reset while in INC: no PC strobe in the reset cycle, IDLE afterwards.
    Run = 1'b1; step();
    Mem_Ack = 1'b1; Instr_Len = 2'd1; step();
    Reset = 1'b1; Mem_Ack = 1'b0;
    #1;
    check("rst_inc_no_strobe", {30'd0, PC_Load_En, PC_Inc_nLoad}, 32'd0);
    step();
    Reset = 1'b0; Run = 1'b0;
    #1;
    check("rst_inc_busy", {31'd0, Busy}, 32'd0);
    check("rst_inc_strobes", {28'd0, PC_Load_En, PC_Out_En, Mem_Rd, Exec_Start}, 32'd0);
    check("rst_inc_count", {16'd0, Instr_Count}, 32'd0);
    check("rst_inc_pc", {16'd0, pc}, {16'd0, model_pc});
    model_cnt = 0; in_fetch = 1'b0;

    // Reset while in EXEC.
    run_instr(2'd1, 0, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    Mem_Ack = 1'b1; step();
    Mem_Ack = 1'b0; step();
    step();
    Exec_Done = 1'b0; Reset = 1'b1; step();
    Reset = 1'b0; Run = 1'b0;
    #1;
    model_pc = model_pc + 16'd1;
    check("rst_exec_busy", {31'd0, Busy}, 32'd0);
    check("rst_exec_strobes", {28'd0, PC_Load_En, PC_Out_En, Mem_Rd, Exec_Start}, 32'd0);
    check("rst_exec_count", {16'd0, Instr_Count}, 32'd0);
    check("rst_exec_pc", {16'd0, pc}, {16'd0, model_pc});
    model_cnt = 0; in_fetch = 1'b0;

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      run_instr(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 4) != 0));
    end

`ifdef EPMP_SEQ_FETCH_TIMEOUT_EN
    // Fetch timeout after 4 unacknowledged FETCH cycles; sticky until Reset.
    Reset = 1'b1; step();
    Reset = 1'b0; model_cnt = 0; in_fetch = 1'b0;
    Run = 1'b1; Mem_Ack = 1'b0; step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_fetch", {30'd0, Mem_Rd, PC_Load_En}, 32'h2);
      step();
    end
    #1;
    check("to_idle", {31'd0, Busy}, 32'd0);
    check("to_bus_err", {31'd0, Bus_Err}, 32'd1);
    check("to_pc", {16'd0, pc}, {16'd0, model_pc});
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check("to_no_restart", {30'd0, Busy, Mem_Rd}, 32'd0);
    end
    Reset = 1'b1; step();
    Reset = 1'b0; Run = 1'b0;
    #1;
    check("to_cleared", {31'd0, Bus_Err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
